// File: rtl/instruction_sequencer_pkg.sv
// instruction_sequencer_pkg: FSM encodings, opcode constants and decode helper
package instruction_sequencer_pkg;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_OPERAND = 3'd2, S_EXEC = 3'd3, S_WB = 3'd4;
  localparam logic [7:0] OP_MOV_AI = 8'h74, OP_MOV_AR = 8'hE8, OP_MOV_RI = 8'h78, OP_ADD = 8'h24,
                         OP_SUBB = 8'h94, OP_ANL = 8'h54, OP_ORL = 8'h44, OP_XRL = 8'h64,
                         OP_SJMP = 8'h80, OP_NOP = 8'h00;
  typedef struct packed {
    logic legal;
    logic two_byte;
    logic sjmp;
    logic wr_rn;
    logic wr_cy;
  } decode_t;
  function automatic decode_t decode(input logic [7:0] op);
    logic alu_grp, imm, rn, ri, sj;
    alu_grp = op[7:4] inside {OP_ADD[7:4], OP_SUBB[7:4], OP_ANL[7:4], OP_ORL[7:4], OP_XRL[7:4]};
    imm = (alu_grp || op[7:4] == OP_MOV_AI[7:4]) && op[3:0] == OP_ADD[3:0];
    rn = (alu_grp || op[7:4] == OP_MOV_AR[7:4]) && op[3];
    ri = op[7:3] == OP_MOV_RI[7:3];
    sj = op == OP_SJMP;
    decode.legal = imm || rn || ri || sj;
    decode.two_byte = imm || ri || sj;
    decode.sjmp = sj;
    decode.wr_rn = ri;
    decode.wr_cy = op[7:4] inside {OP_ADD[7:4], OP_SUBB[7:4]};
  endfunction
endpackage

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: sequencer-to-ALU operand/result bus
interface instruction_sequencer_if;
  logic [7:0] alu_opcode;
  logic [7:0] alu_operand1;
  logic [7:0] alu_operand2;
  logic [8:0] alu_result;
  logic       alu_psw_c;
  modport master(output alu_opcode, alu_operand1, alu_operand2, input alu_result, alu_psw_c);
  modport slave(input alu_opcode, alu_operand1, alu_operand2, output alu_result, alu_psw_c);
endinterface

// File: rtl/instruction_sequencer_register_bank.sv
// register_bank: R0-R7, one synchronous write port and one combinational read port
module register_bank (
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] r [8];
  assign rdata = r[raddr];
  // write port; reset clears every register
  always_ff @(posedge clock)
    if (reset) r <= '{default: '0};
    else if (we) r[waddr] <= wdata;
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/writeback controller wrapped around the ALU
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   rom_addr,
  input  logic [7:0]            rom_data,
  instruction_sequencer_if.master alu,
  output logic [7:0]            acc,
  output logic                  psw_cy,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  instr_done,
  output logic                  illegal_op
);
  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;
  logic [2:0] state;
  logic [7:0] ir, rn_rdata;
  decode_t d;
  assign rom_addr = pc;
  // in DECODE the opcode is still on the ROM bus, afterwards it lives in ir
  assign d = decode(state == S_DECODE ? rom_data : ir);
  register_bank u_bank (
    .clock,
    .reset,
    .we(state == S_WB && d.wr_rn),
    .waddr(ir[2:0]),
    .wdata(alu.alu_result[7:0]),
    .raddr(ir[2:0]),
    .rdata(rn_rdata)
  );
  // instruction FSM, ALU operand registers and architectural state
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      acc <= '0;
      psw_cy <= 1'b0;
      alu.alu_opcode <= OP_NOP;
      alu.alu_operand1 <= '0;
      alu.alu_operand2 <= '0;
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      instr_done <= state == S_WB || (state == S_OPERAND && d.sjmp);
      illegal_op <= state == S_DECODE && !d.legal;
      case (state)
        S_FETCH: begin
          pc <= pc + PC_ONE;
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir <= rom_data;
          if (d.two_byte) pc <= pc + PC_ONE;
          state <= d.legal ? S_OPERAND : S_FETCH;
        end
        S_OPERAND:
          if (d.sjmp) begin
            pc <= pc + {{(PC_WIDTH-8){rom_data[7]}}, rom_data};
            state <= S_FETCH;
          end else begin
            alu.alu_opcode <= ir;
            alu.alu_operand1 <= acc;
            alu.alu_operand2 <= d.two_byte ? rom_data : rn_rdata;
            state <= S_EXEC;
          end
        S_EXEC: begin
          alu.alu_opcode <= OP_NOP;
          state <= S_WB;
        end
        S_WB: begin
          if (!d.wr_rn) acc <= alu.alu_result[7:0];
          if (d.wr_cy) psw_cy <= alu.alu_psw_c;
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed scoreboard bench with ROM and ALU models
module tb_instruction_sequencer;
  logic clock = 1'b0, reset = 1'b1;
  logic [15:0] rom_addr, pc;
  logic [7:0] rom_data, acc;
  logic psw_cy, instr_done, illegal_op;
  instruction_sequencer_if bus ();
  instruction_sequencer dut (
    .clock,
    .reset,
    .rom_addr,
    .rom_data,
    .alu(bus),
    .acc,
    .psw_cy,
    .pc,
    .instr_done,
    .illegal_op
  );
  always #5 clock = ~clock;

  logic [7:0] mem [0:65535];
  always @(posedge clock) rom_data <= mem[rom_addr];

  // ALU model: registered result, holds while opcode is 00; logic ops keep the carry
  logic [8:0] alu_q;
  function automatic logic [8:0] alu_fn(input logic [7:0] op, a, b, input logic c);
    case (op[7:4])
      4'h2: return {1'b0, a} + {1'b0, b};
      4'h9: return {1'b0, a} - {1'b0, b};
      4'h5: return {c, a & b};
      4'h4: return {c, a | b};
      4'h6: return {c, a ^ b};
      default: return {c, b};
    endcase
  endfunction
  always @(posedge clock)
    if (reset) alu_q <= '0;
    else if (bus.alu_opcode != 8'h00) alu_q <= alu_fn(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2, alu_q[8]);
  assign bus.alu_result = alu_q;
  assign bus.alu_psw_c = alu_q[8];

  typedef struct {
    logic [7:0]  acc;
    logic        cy;
    logic [15:0] pc;
    int          gap;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int compared = 0, mismatched = 0, cyc = 0, last_done = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every instr_done pulse pops one expectation
  always @(negedge clock)
    if (!reset && instr_done) begin
      check("done_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e_m = q.pop_front();
        check("done_acc", acc, e_m.acc);
        check("done_cy", psw_cy, e_m.cy);
        check("done_pc", pc, e_m.pc);
        check("done_gap", cyc - last_done, e_m.gap);
      end
      last_done = cyc;
    end

  task automatic push(input logic [7:0] a, input logic c, input logic [15:0] p, input int g);
    q.push_back('{acc: a, cy: c, pc: p, gap: g});
  endtask
  task automatic begin_test();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    q.delete();
  endtask
  task automatic go();
    reset = 1'b0;
    last_done = cyc;
  endtask
  task automatic wait_empty(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(q.size()), 0);
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_acc"}, acc, 0);
    check({tag, "_cy"}, psw_cy, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_opcode"}, bus.alu_opcode, 0);
    check({tag, "_done"}, instr_done, 0);
    check({tag, "_illegal"}, illegal_op, 0);
  endtask

  initial begin
    // reset state, then MOV A,#05 / ADD A,#03 with opcode visible only in EXEC
    begin_test();
    check_reset_state("rst");
    check("rst_op1", bus.alu_operand1, 0);
    check("rst_op2", bus.alu_operand2, 0);
    mem[0] = 8'h74; mem[1] = 8'h05; mem[2] = 8'h24; mem[3] = 8'h03;
    push(8'h05, 1'b0, 16'h0002, 5);
    push(8'h08, 1'b0, 16'h0004, 5);
    go();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      check("t1_alu_opcode", bus.alu_opcode, c == 3 ? 8'h74 : c == 8 ? 8'h24 : 8'h00);
      if (c == 8) begin
        check("t1_op1", bus.alu_operand1, 8'h05);
        check("t1_op2", bus.alu_operand2, 8'h03);
      end
    end
    wait_empty("t1_drain");
    // ADD with carry out, then SUBB with borrow
    begin_test();
    mem[0] = 8'h74; mem[1] = 8'hF0; mem[2] = 8'h24; mem[3] = 8'h20; mem[4] = 8'h94; mem[5] = 8'h20;
    push(8'hF0, 1'b0, 16'h0002, 5);
    push(8'h10, 1'b1, 16'h0004, 5);
    push(8'hF0, 1'b1, 16'h0006, 5);
    go();
    wait_empty("t2_drain");
    // MOV R3,#5A / MOV A,R3 / ANL A,#0F
    begin_test();
    mem[0] = 8'h7B; mem[1] = 8'h5A; mem[2] = 8'hEB; mem[3] = 8'h54; mem[4] = 8'h0F;
    push(8'h00, 1'b0, 16'h0002, 5);
    push(8'h5A, 1'b0, 16'h0003, 5);
    push(8'h0A, 1'b0, 16'h0005, 5);
    go();
    wait_empty("t3_drain");
    // SJMP -2 loops on itself every 3 cycles
    begin_test();
    mem[0] = 8'h80; mem[1] = 8'hFE;
    repeat (3) push(8'h00, 1'b0, 16'h0000, 3);
    go();
    wait_empty("t4_drain");
    // SJMP -3 wraps the branch to FFFF, 1-byte MOV A,R0 there wraps the increment to 0000
    begin_test();
    mem[0] = 8'h80; mem[1] = 8'hFD; mem[16'hFFFF] = 8'hE8;
    push(8'h00, 1'b0, 16'hFFFF, 3);
    push(8'h00, 1'b0, 16'h0000, 5);
    push(8'h00, 1'b0, 16'hFFFF, 3);
    go();
    wait_empty("t5_drain");
    // unsupported A5 pulses illegal_op once and costs 2 cycles
    begin_test();
    mem[0] = 8'hA5; mem[1] = 8'h74; mem[2] = 8'h11;
    push(8'h11, 1'b0, 16'h0003, 7);
    go();
    @(negedge clock);
    check("t6_illegal_early", illegal_op, 0);
    @(negedge clock);
    check("t6_illegal_pulse", illegal_op, 1);
    check("t6_acc_hold", acc, 0);
    check("t6_pc", pc, 16'h0001);
    @(negedge clock);
    check("t6_illegal_end", illegal_op, 0);
    wait_empty("t6_drain");
    // reset in the WB cycle of ADD A,#01 aborts it, then the program reruns from 0000
    begin_test();
    mem[0] = 8'h74; mem[1] = 8'hFF; mem[2] = 8'h24; mem[3] = 8'h01;
    push(8'hFF, 1'b0, 16'h0002, 5);
    go();
    repeat (9) @(negedge clock);
    check("t7_pre_empty", 32'(q.size()), 0);
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("t7_rst");
    push(8'hFF, 1'b0, 16'h0002, 5);
    push(8'h00, 1'b1, 16'h0004, 5);
    go();
    wait_empty("t7_drain");
    reset = 1'b1;
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
